multi_data_sync: RTL

MULTI_DATA_SYNC -- requirements
Module: multi_data_sync

---
 rtl/multi_data_sync.sv | 98 +++++++++
 1 files changed

// File: rtl/multi_data_sync.sv
// Multi-channel enable-qualified bus synchroniser with a per-channel valid/ready hold register.
// Optional sticky overwrite flag is compiled in with `define MULTI_DATA_SYNC_OVERRUN_EN.
module multi_data_sync #(
    parameter int unsigned BUS_WIDTH   = 8,
    parameter int unsigned NUM_STAGES  = 2,
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned TOGGLE_MODE = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CH*BUS_WIDTH-1:0]   unsync_bus,
    input  logic [NUM_CH-1:0]             bus_enable,
    input  logic [NUM_CH-1:0]             out_ready,
    output logic [NUM_CH*BUS_WIDTH-1:0]   sync_bus,
    output logic [NUM_CH-1:0]             sync_valid,
    output logic [NUM_CH-1:0]             enable_pulse
`ifdef MULTI_DATA_SYNC_OVERRUN_EN
    ,
    input  logic [NUM_CH-1:0]             overrun_clr,
    output logic [NUM_CH-1:0]             overrun
`endif
);

    localparam int unsigned LAST = NUM_STAGES - 1;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic [NUM_STAGES-1:0] sync_q;
        logic                  prev_q;
        logic                  event_c;
        logic [BUS_WIDTH-1:0]  data_q;
        logic                  valid_q;
        logic                  valid_d;
        logic                  pulse_q;

        // Enable synchroniser chain plus history flop for edge detection
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                sync_q <= '0;
                prev_q <= 1'b0;
            end else begin
                sync_q <= {sync_q[NUM_STAGES-2:0], bus_enable[ch]};
                prev_q <= sync_q[LAST];
            end
        end

        if (TOGGLE_MODE == 0) begin : g_level
            assign event_c = sync_q[LAST] & ~prev_q;
        end else begin : g_toggle
            assign event_c = sync_q[LAST] ^ prev_q;
        end

        // A capture always wins over a same-edge accept
        always_comb begin
            valid_d = valid_q;
            if (event_c) begin
                valid_d = 1'b1;
            end else if (valid_q && out_ready[ch]) begin
                valid_d = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                data_q  <= '0;
                valid_q <= 1'b0;
                pulse_q <= 1'b0;
            end else begin
                if (event_c) begin
                    data_q <= unsync_bus[ch*BUS_WIDTH +: BUS_WIDTH];
                end
                valid_q <= valid_d;
                pulse_q <= event_c;
            end
        end

`ifdef MULTI_DATA_SYNC_OVERRUN_EN
        logic overrun_q;

        // Sticky flag: unconsumed data overwritten by a new capture
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                overrun_q <= 1'b0;
            end else if (event_c && valid_q && !out_ready[ch]) begin
                overrun_q <= 1'b1;
            end else if (overrun_clr[ch]) begin
                overrun_q <= 1'b0;
            end
        end

        assign overrun[ch] = overrun_q;
`endif

        assign sync_bus[ch*BUS_WIDTH +: BUS_WIDTH] = data_q;
        assign sync_valid[ch]                      = valid_q;
        assign enable_pulse[ch]                    = pulse_q;
    end

endmodule
